jstk_spi_responder: RTL and testbench

SPI slave that emulates one PmodJSTK joystick, driven by the same 5-byte transaction the paddle controller's SPI master issues. It returns a frame-consistent snapshot of supplied X/Y/button values and captures the LED command byte sent by the master. It lets the pong design be exercised in simulation and on the bench without physical joysticks: a test harness or a CPU-driven "virtual player" feeds positions, and the master under test reads them over SPI.

---
 rtl/jstk_spi_responder.sv | 104 ++++++++++
 tb/tb_jstk_spi_responder.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder: SPI mode-0 slave emulating one PmodJSTK with frame-consistent X/Y/button snapshot and LED capture
module jstk_spi_responder #(
    parameter int FRAME_BYTES = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk50M,
    input  logic       reset,
    input  logic       cs,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] buttons,
    output logic [1:0] led,
    output logic       frame_done,
    output logic       frame_error
);
    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_HIGH} state_t;
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
    logic cs_d, sck_d, cs_s, sck_s, mosi_s;
    logic cs_fall, cs_rise, sck_rise, sck_fall;
    logic [9:0] hold_x, hold_y;
    logic [2:0] hold_b;
    logic [7:0] tx, rx, cmd, next_byte, rx_n;
    logic [2:0] bit_cnt, byte_cnt;
    always_ff @(posedge clk50M) begin
        cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
        sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        cs_d      <= cs_s;
        sck_d     <= sck_s;
    end
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign cs_fall  = cs_d & ~cs_s;
    assign cs_rise  = ~cs_d & cs_s;
    assign sck_rise = ~sck_d & sck_s & ~cs_s;
    assign sck_fall = sck_d & ~sck_s & ~cs_s;
    assign rx_n     = {rx[6:0], mosi_s};
    always_comb begin
        next_byte = byte_cnt == 3'd0 ? hold_x[7:0] :
                    byte_cnt == 3'd1 ? {6'b0, hold_x[9:8]} :
                    byte_cnt == 3'd2 ? hold_y[7:0] :
                    byte_cnt == 3'd3 ? {6'b0, hold_y[9:8]} :
                    byte_cnt == 3'd4 ? {5'b0, hold_b} : 8'h00;
        miso = (state == SHIFT && !cs_s) ? tx[7] : 1'b0;
        state_n = state;
        case (state)
            IDLE:      state_n = cs_fall ? SHIFT : (!cs_s ? WAIT_HIGH : IDLE);
            SHIFT:     state_n = cs_rise ? IDLE : SHIFT;
            WAIT_HIGH: state_n = cs_s ? IDLE : WAIT_HIGH;
            default:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk50M) begin
        if (reset) begin
            state       <= IDLE;
            led         <= 2'b00;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            bit_cnt     <= 3'd0;
            byte_cnt    <= 3'd0;
            tx          <= 8'h00;
            rx          <= 8'h00;
            cmd         <= 8'h00;
            hold_x      <= 10'd0;
            hold_y      <= 10'd0;
            hold_b      <= 3'd0;
        end else begin
            state       <= state_n;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            if (state == IDLE && cs_fall) begin
                hold_x   <= x_pos;
                hold_y   <= y_pos;
                hold_b   <= buttons;
                tx       <= x_pos[7:0];
                bit_cnt  <= 3'd0;
                byte_cnt <= 3'd0;
            end else if (state == SHIFT) begin
                if (cs_rise) begin
                    if (byte_cnt == 3'(FRAME_BYTES) && bit_cnt == 3'd0) begin
                        frame_done <= 1'b1;
                        if (cmd[7]) led <= cmd[1:0];
                    end else begin
                        frame_error <= 1'b1;
                    end
                end else if (sck_rise) begin
                    rx      <= rx_n;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_cnt <= byte_cnt == 3'd7 ? byte_cnt : byte_cnt + 3'd1;
                        if (byte_cnt == 3'd0) cmd <= rx_n;
                    end
                end else if (sck_fall) begin
                    tx <= bit_cnt == 3'd0 ? next_byte : {tx[6:0], 1'b0};
                end
            end
        end
    end
endmodule

// File: tb/tb_jstk_spi_responder.sv
// tb_jstk_spi_responder: directed SPI master with a byte scoreboard for the joystick responder
module tb_jstk_spi_responder;
    localparam int H = 25;
    logic clk50M = 1'b0, reset = 1'b1, cs = 1'b1, sck = 1'b0, mosi = 1'b0;
    logic miso, frame_done, frame_error;
    logic [9:0] x_pos = 10'd0, y_pos = 10'd0;
    logic [2:0] buttons = 3'd0;
    logic [1:0] led;
    logic [7:0] exp_q[$];
    logic [7:0] mb[8];
    int passed = 0, total = 0, done_cnt = 0, err_cnt = 0;
    jstk_spi_responder dut (
        .clk50M(clk50M), .reset(reset), .cs(cs), .sck(sck), .mosi(mosi), .miso(miso),
        .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons), .led(led),
        .frame_done(frame_done), .frame_error(frame_error)
    );
    always #10 clk50M = ~clk50M;
    always @(negedge clk50M) begin
        if (frame_done) done_cnt++;
        if (frame_error) err_cnt++;
    end
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask
    task automatic frame(input int n, input int chk_n, input int chg_byte, input logic [9:0] chg_x, input int rst_byte);
        logic [7:0] rb;
        logic [7:0] e;
        @(negedge clk50M) cs = 1'b0;
        repeat (10) @(negedge clk50M);
        for (int i = 0; i < n; i++) begin
            rb = 8'h00;
            for (int b = 7; b >= 0; b--) begin
                mosi = mb[i][b];
                repeat (H) @(negedge clk50M);
                rb = {rb[6:0], miso};
                sck = 1'b1;
                repeat (H) @(negedge clk50M);
                sck = 1'b0;
                if (i == rst_byte && b == 5) begin
                    reset = 1'b1;
                    @(negedge clk50M) reset = 1'b0;
                end
            end
            if (i < chk_n) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk($sformatf("miso_byte%0d", i), {8'h00, rb}, {8'h00, e});
                end else chk("scoreboard_empty", 16'd1, 16'd0);
            end
            if (i == chg_byte) x_pos = chg_x;
        end
        repeat (H) @(negedge clk50M);
        cs = 1'b1;
        mosi = 1'b0;
        repeat (12) @(negedge clk50M);
    endtask
    task automatic push5(input logic [7:0] b0, b1, b2, b3, b4);
        exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
        exp_q.push_back(b3); exp_q.push_back(b4);
    endtask
    task automatic set_mb(input logic [7:0] c);
        mb[0] = c;
        for (int i = 1; i < 8; i++) mb[i] = 8'h00;
    endtask
    task automatic pulses(input string tag, input int d0, input int e0, input int dd, input int de);
        chk({tag, "_done"}, 16'(done_cnt - d0), 16'(dd));
        chk({tag, "_err"}, 16'(err_cnt - e0), 16'(de));
    endtask
    initial begin
        int d0, e0, mhi;
        repeat (5) @(negedge clk50M);
        reset = 1'b0;
        repeat (5) @(negedge clk50M);
        chk("reset_miso", {15'd0, miso}, 16'd0);
        chk("reset_led", {14'd0, led}, 16'd0);
        d0 = done_cnt; e0 = err_cnt; mhi = 0;
        for (int c = 0; c < 1000; c++) begin
            if (c % 7 == 0) sck = ~sck;
            mosi = c[3];
            @(negedge clk50M);
            if (miso) mhi++;
        end
        sck = 1'b0;
        chk("idle_miso_high_cycles", 16'(mhi), 16'd0);
        pulses("idle", d0, e0, 0, 0);
        chk("idle_led", {14'd0, led}, 16'd0);
        x_pos = 10'h2A5; y_pos = 10'h133; buttons = 3'b101;
        set_mb(8'h83);
        push5(8'hA5, 8'h02, 8'h33, 8'h01, 8'h05);
        d0 = done_cnt; e0 = err_cnt;
        frame(5, 5, -1, 10'd0, -1);
        pulses("frame1", d0, e0, 1, 0);
        chk("frame1_led", {14'd0, led}, 16'd3);
        set_mb(8'h02);
        push5(8'hA5, 8'h02, 8'h33, 8'h01, 8'h05);
        d0 = done_cnt; e0 = err_cnt;
        frame(5, 5, 1, 10'h3FF, -1);
        pulses("midchange", d0, e0, 1, 0);
        chk("nocmd_led", {14'd0, led}, 16'd3);
        set_mb(8'h80);
        push5(8'hFF, 8'h03, 8'h33, 8'h01, 8'h05);
        d0 = done_cnt; e0 = err_cnt;
        frame(5, 5, -1, 10'd0, -1);
        pulses("newx", d0, e0, 1, 0);
        chk("led_00", {14'd0, led}, 16'd0);
        set_mb(8'h83);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h03); exp_q.push_back(8'h33);
        d0 = done_cnt; e0 = err_cnt;
        frame(3, 3, -1, 10'd0, -1);
        pulses("short", d0, e0, 0, 1);
        chk("short_led", {14'd0, led}, 16'd0);
        push5(8'hFF, 8'h03, 8'h33, 8'h01, 8'h05);
        exp_q.push_back(8'h00);
        d0 = done_cnt; e0 = err_cnt;
        frame(6, 6, -1, 10'd0, -1);
        pulses("long", d0, e0, 0, 1);
        chk("long_led", {14'd0, led}, 16'd0);
        set_mb(8'h81);
        frame(5, 0, -1, 10'd0, -1);
        chk("led_01", {14'd0, led}, 16'd1);
        set_mb(8'h83);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h03);
        d0 = done_cnt; e0 = err_cnt;
        frame(5, 2, -1, 10'd0, 2);
        pulses("reset_mid", d0, e0, 0, 0);
        chk("reset_mid_led", {14'd0, led}, 16'd0);
        x_pos = 10'h155; y_pos = 10'h2CC; buttons = 3'b010;
        set_mb(8'h82);
        push5(8'h55, 8'h01, 8'hCC, 8'h02, 8'h02);
        d0 = done_cnt; e0 = err_cnt;
        frame(5, 5, -1, 10'd0, -1);
        pulses("after_reset", d0, e0, 1, 0);
        chk("after_reset_led", {14'd0, led}, 16'd2);
        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
